// File: rtl/ppu_out_packer_if.sv
// AXI4-Stream style bus carrying packed result beats toward the output DMA.
interface ppu_out_packer_if #(
  parameter int unsigned OUT_W = 64
) ();
  logic [OUT_W-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ppu_out_packer.sv
// Buffers PPU result vectors in a FIFO and serialises them into OUT_W-bit stream beats,
// framing every cfg_num_vecs vectors with tlast followed by a one-cycle o_done pulse.
module ppu_out_packer #(
  parameter int unsigned ARRAY_COL  = 16,
  parameter int unsigned OUT_W      = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [ARRAY_COL*8-1:0] i_data_vec,
  output logic                   o_almost_full,
  input  logic                   i_start,
  input  logic [15:0]            cfg_num_vecs,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow,
  ppu_out_packer_if.master       m_axis
);

  localparam int unsigned VecW  = ARRAY_COL * 8;
  localparam int unsigned Beats = VecW / OUT_W;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [VecW-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [15:0]       rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              empty, full, run, tvalid, last_beat, hs, pop, push, drop;
  logic [VecW-1:0]   head;
  logic [OUT_W-1:0]  beat_data;

  // FIFO status and stream handshake decode
  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == CntW'(FIFO_DEPTH));
    run       = (state_q == StRun);
    head      = mem_q[rd_ptr_q];
    tvalid    = run && !empty;
    last_beat = (beat_q == BeatW'(Beats - 1));
    hs        = tvalid && m_axis.tready;
    pop       = hs && last_beat;
    // A full FIFO still accepts a vector when the head leaves in the same cycle.
    push      = i_valid && (!full || pop);
    drop      = i_valid && full && !pop;
  end

  // Select the current beat slice of the head vector; beat 0 carries the low lanes
  always_comb begin
    beat_data = '0;
    for (int unsigned b = 0; b < Beats; b++) begin
      if (beat_q == BeatW'(b)) begin
        beat_data = head[b*OUT_W +: OUT_W];
      end
    end
  end

  // Next-state logic for the FSM, FIFO pointers and frame counters
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          ovf_d = 1'b0;
          rem_d = cfg_num_vecs;
          if (cfg_num_vecs == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (hs) begin
          beat_d = last_beat ? '0 : beat_q + BeatW'(1);
          if (last_beat) begin
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A drop in the same cycle as a frame start still counts as an overflow.
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Vector storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data_vec;
    end
  end

  // Outputs are forced low while reset is held
  always_comb begin
    m_axis.tvalid = rst_n && tvalid;
    m_axis.tdata  = (rst_n && tvalid) ? beat_data : '0;
    m_axis.tlast  = rst_n && tvalid && last_beat && (rem_q == 16'd1);
    o_almost_full = rst_n && (32'(cnt_q) >= FIFO_DEPTH - AF_MARGIN);
    o_busy        = rst_n && run;
    o_done        = rst_n && done_q;
    o_overflow    = rst_n && ovf_q;
  end

endmodule

// File: tb/tb_ppu_out_packer.sv
// Self-checking bench for ppu_out_packer: table-driven single-vector frames, directed corner
// sequences and randomised frames checked against a queue of expected beats.
module tb_ppu_out_packer;

  localparam int unsigned VecW  = 128;
  localparam int unsigned OutW  = 64;
  localparam int unsigned Beats = VecW / OutW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_start = 1'b0;
  logic [VecW-1:0] i_data_vec = '0;
  logic [15:0]     cfg_num_vecs = '0;
  logic            o_almost_full, o_busy, o_done, o_overflow;

  ppu_out_packer_if #(.OUT_W(OutW)) axis ();

  ppu_out_packer #(
    .ARRAY_COL (16),
    .OUT_W     (OutW),
    .FIFO_DEPTH(16),
    .AF_MARGIN (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_data_vec   (i_data_vec),
    .o_almost_full(o_almost_full),
    .i_start      (i_start),
    .cfg_num_vecs (cfg_num_vecs),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_overflow   (o_overflow),
    .m_axis       (axis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OutW-1:0] data;
    logic            last;
  } beat_t;

  typedef struct {
    logic [VecW-1:0] vec;
    logic [OutW-1:0] b0;
    logic [OutW-1:0] b1;
  } vec_rec_t;

  beat_t exp_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    hs_cnt = 0;
  int    done_cnt = 0;

  task automatic chk(input string name, input logic [VecW-1:0] act, input logic [VecW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected stream for one vector: consecutive OutW slices, low lanes first.
  function automatic void add_vec(input logic [VecW-1:0] v, input logic last);
    beat_t e;
    for (int b = 0; b < int'(Beats); b++) begin
      e.data = v[b*OutW +: OutW];
      e.last = last && (b == int'(Beats) - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic logic [VecW-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stream monitor: scoreboard on handshakes, hold checks while stalled
  logic            stall_q = 1'b0;
  logic [OutW-1:0] prev_data = '0;
  logic            prev_last = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (stall_q) begin
        chk("hold_tvalid", axis.tvalid, 1'b1);
        chk("hold_tdata", axis.tdata, prev_data);
        chk("hold_tlast", axis.tlast, prev_last);
      end
      if (!axis.tvalid) chk("tlast_without_tvalid", axis.tlast, 1'b0);
      if (axis.tvalid && axis.tready) begin
        hs_cnt <= hs_cnt + 1;
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_tdata", axis.tdata, e.data);
          chk("beat_tlast", axis.tlast, e.last);
        end
      end
      stall_q   <= axis.tvalid && !axis.tready;
      prev_data <= axis.tdata;
      prev_last <= axis.tlast;
    end else begin
      stall_q <= 1'b0;
    end
    if (o_done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int n);
    cfg_num_vecs = 16'(n);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic push(input logic [VecW-1:0] v);
    i_valid = 1'b1;
    i_data_vec = v;
    tick();
    i_valid = 1'b0;
  endtask

  // mode 0: tready high, 1: toggling, 2: random
  task automatic drain(input int budget, input int mode);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      case (mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = !axis.tready;
        default: axis.tready = 1'($urandom_range(0, 1));
      endcase
      tick();
    end
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_tvalid"}, axis.tvalid, 1'b0);
    chk({name, "_tlast"}, axis.tlast, 1'b0);
    chk({name, "_tdata"}, axis.tdata, '0);
    chk({name, "_busy"}, o_busy, 1'b0);
    chk({name, "_done"}, o_done, 1'b0);
    chk({name, "_overflow"}, o_overflow, 1'b0);
    chk({name, "_almost_full"}, o_almost_full, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_rec_t        tbl[4];
    logic [VecW-1:0] v [18];
    logic [VecW-1:0] va, vb;
    int              d0, h0, n, start_at;

    tbl[0] = '{128'h0F0E0D0C0B0A09080706050403020100,
               64'h0706050403020100, 64'h0F0E0D0C0B0A0908};
    tbl[1] = '{{128{1'b1}}, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    tbl[2] = '{128'h80000000000000000000000000000001,
               64'h0000000000000001, 64'h8000000000000000};
    tbl[3] = '{128'hDEADBEEF00112233CAFEF00D44556677,
               64'hCAFEF00D44556677, 64'hDEADBEEF00112233};

    // Reset state
    axis.tready = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Table: single-vector frames with hand-computed beats
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      exp_q.push_back('{tbl[i].b0, 1'b0});
      exp_q.push_back('{tbl[i].b1, 1'b1});
      axis.tready = 1'b1;
      start(1);
      chk("tbl_busy", o_busy, 1'b1);
      push(tbl[i].vec);
      chk("tbl_first_beat_latency", axis.tdata, tbl[i].b0);
      drain(50, 0);
      tick();
      tick();
      chk("tbl_done_count", done_cnt - d0, 1);
      chk("tbl_idle", o_busy, 1'b0);
    end

    // Four back-to-back pushes with tready toggling
    d0 = done_cnt;
    h0 = hs_cnt;
    start(4);
    for (int k = 0; k < 4; k++) begin
      v[k] = rand_vec();
      add_vec(v[k], k == 3);
      axis.tready = (k % 2 == 0);
      push(v[k]);
    end
    drain(100, 1);
    tick();
    tick();
    chk("t2_beat_count", hs_cnt - h0, 8);
    chk("t2_done_count", done_cnt - d0, 1);

    // Overfill in IDLE, then one 16-vector frame
    axis.tready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      v[k] = rand_vec();
      if (k < 16) add_vec(v[k], k == 15);
      push(v[k]);
      if (k == 12) chk("t3_af_at_13", o_almost_full, 1'b0);
      if (k == 13) chk("t3_af_at_14", o_almost_full, 1'b1);
      if (k == 15) chk("t3_no_ovf_at_16", o_overflow, 1'b0);
    end
    chk("t3_ovf_at_17", o_overflow, 1'b1);
    chk("t3_no_tvalid_idle", axis.tvalid, 1'b0);
    d0 = done_cnt;
    h0 = hs_cnt;
    start(16);
    chk("t3_ovf_cleared", o_overflow, 1'b0);
    drain(200, 0);
    tick();
    tick();
    chk("t3_beat_count", hs_cnt - h0, 32);
    chk("t3_done_count", done_cnt - d0, 1);

    // Full FIFO in RUN: push on the pop cycle is accepted
    axis.tready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      v[k] = rand_vec();
      add_vec(v[k], 1'b0);
      push(v[k]);
    end
    v[16] = rand_vec();
    v[17] = rand_vec();
    add_vec(v[16], 1'b1);
    d0 = done_cnt;
    start(17);
    axis.tready = 1'b1;
    tick();
    i_valid = 1'b1;
    i_data_vec = v[16];
    tick();
    i_valid = 1'b0;
    chk("t4_no_ovf_on_swap", o_overflow, 1'b0);
    chk("t4_af_still", o_almost_full, 1'b1);
    axis.tready = 1'b0;
    push(v[17]);
    chk("t4_still_full", o_overflow, 1'b1);
    drain(200, 0);
    tick();
    tick();
    chk("t4_done_count", done_cnt - d0, 1);

    // Zero-length frame
    d0 = done_cnt;
    start(0);
    chk("t5_done_pulse", o_done, 1'b1);
    chk("t5_busy", o_busy, 1'b0);
    chk("t5_ovf_cleared", o_overflow, 1'b0);
    chk("t5_no_tvalid", axis.tvalid, 1'b0);
    tick();
    chk("t5_done_single", o_done, 1'b0);
    tick();
    chk("t5_done_count", done_cnt - d0, 1);

    // Reset after three beats of a two-vector frame
    va = rand_vec();
    vb = rand_vec();
    push(va);
    push(vb);
    exp_q.push_back('{va[63:0], 1'b0});
    exp_q.push_back('{va[127:64], 1'b0});
    exp_q.push_back('{vb[63:0], 1'b0});
    d0 = done_cnt;
    h0 = hs_cnt;
    axis.tready = 1'b1;
    start(2);
    tick();
    tick();
    tick();
    chk("t6_tlast_pending", axis.tlast, 1'b1);
    rst_n = 1'b0;
    axis.tready = 1'b0;
    #1;
    chk_all_zero("t6_during_reset");
    tick();
    chk_all_zero("t6_after_reset_edge");
    rst_n = 1'b1;
    tick();
    tick();
    chk_all_zero("t6_released");
    chk("t6_beats_before_reset", hs_cnt - h0, 3);
    chk("t6_no_done", done_cnt - d0, 0);
    va = rand_vec();
    add_vec(va, 1'b1);
    d0 = done_cnt;
    axis.tready = 1'b1;
    start(1);
    push(va);
    drain(50, 0);
    tick();
    tick();
    chk("t6_new_frame_done", done_cnt - d0, 1);

    // Randomised frames: random sizes, push gaps, start timing and backpressure
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 8);
      start_at = $urandom_range(0, n);
      d0 = done_cnt;
      for (int k = 0; k <= n; k++) begin
        if (k == start_at) begin
          axis.tready = 1'($urandom_range(0, 1));
          start(n);
        end
        if (k < n) begin
          for (int g = $urandom_range(0, 2); g > 0; g--) begin
            axis.tready = 1'($urandom_range(0, 1));
            tick();
          end
          va = rand_vec();
          add_vec(va, k == n - 1);
          axis.tready = 1'($urandom_range(0, 1));
          push(va);
        end
      end
      drain(300, 2);
      tick();
      tick();
      chk("rand_done_count", done_cnt - d0, 1);
      chk("rand_no_overflow", o_overflow, 1'b0);
      chk("rand_idle", o_busy, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
